// File: rtl/rv32m_mdu_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_mdu_pkg
// Shared encodings for the RV32M multiply/divide unit:
//   - func3 encodings of the eight RV32M operations
//   - FSM state encodings (IDLE / CALC / FIX)
//   - MDU_ITER: number of radix-2 iterations per operation
// ---------------------------------------------------------------------------
package rv32m_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_CALC = 2'd1;
  localparam logic [1:0] MDU_FIX  = 2'd2;

  localparam int MDU_ITER = 32;

  // All divide/remainder encodings have func3[2] set.
  function automatic logic mdu_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/rv32m_mdu.sv
// ---------------------------------------------------------------------------
// rv32m_mdu
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// One product/quotient bit per cycle; 33 edges from acceptance to done.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   start   in   operation request, sampled only while busy=0
//   func3   in   RV32M operation (MUL..REMU)
//   op_a    in   rs1 value (multiplicand / dividend)
//   op_b    in   rs2 value (multiplier / divisor)
//   flush   in   abort any in-flight operation, no done pulse
//   busy    out  high while an accepted operation is in progress
//   done    out  one-cycle pulse, result valid in this cycle
//   result  out  registered result, held until the next done
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, divide-by-zero and signed-overflow
//                     operations go straight from IDLE to FIX (done one
//                     edge after acceptance). Undefined: constant latency.
// ---------------------------------------------------------------------------
module rv32m_mdu
  import rv32m_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(MDU_ITER);

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  // Conditional two's-complement negation (single and double width).
  function automatic logic [XLEN-1:0] f_cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cond_neg_dw(input logic [2*XLEN-1:0] v,
                                                      input logic              neg);
    return neg ? -v : v;
  endfunction

  // Control state
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_func3;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  // Datapath state
  // r_acc: multiply = {partial product hi, multiplier being shifted out}
  //        divide   = {partial remainder, dividend shifting into quotient}
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mag;       // |multiplicand| or |divisor|
  logic              r_neg_main;  // negate product / quotient
  logic              r_neg_rem;   // negate remainder
  logic              r_spec;      // divide-by-zero or signed overflow
  logic [XLEN-1:0]   r_spec_res;

  // Operand decode at acceptance
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_is_div;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_res;

  assign w_a_signed = (func3 == MDU_MULH) || (func3 == MDU_MULHSU) ||
                      (func3 == MDU_DIV)  || (func3 == MDU_REM);
  assign w_b_signed = (func3 == MDU_MULH) || (func3 == MDU_DIV) ||
                      (func3 == MDU_REM);
  assign w_sa       = op_a[XLEN-1] & w_a_signed;
  assign w_sb       = op_b[XLEN-1] & w_b_signed;
  // -(2^31) reinterpreted as unsigned is exactly 2^31, so no overflow here.
  assign w_abs_a    = f_cond_neg(op_a, w_sa);
  assign w_abs_b    = f_cond_neg(op_b, w_sb);
  assign w_is_div   = mdu_is_div(func3);
  assign w_div0     = w_is_div && (op_b == '0);
  assign w_ovf      = ((func3 == MDU_DIV) || (func3 == MDU_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign w_special  = w_div0 || w_ovf;

  // func3[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
  always_comb begin
    w_spec_res = '0;
    if (w_div0) begin
      w_spec_res = func3[1] ? op_a : '1;
    end else if (w_ovf) begin
      w_spec_res = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_mag} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step on a 33-bit shifted partial remainder. The true
  // difference is below the divisor, so a 32-bit subtract is exact.
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_next;

  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_mag;
  assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_ge};

  // Sign correction and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod = f_cond_neg_dw(r_acc, r_neg_main);
  assign w_quo  = f_cond_neg(r_acc[XLEN-1:0], r_neg_main);
  assign w_rem  = f_cond_neg(r_acc[2*XLEN-1:XLEN], r_neg_rem);

  always_comb begin
    w_fix_res = '0;
    if (r_spec) begin
      w_fix_res = r_spec_res;
    end else begin
      case (r_func3)
        MDU_MUL:                          w_fix_res = w_prod[XLEN-1:0];
        MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
        MDU_DIV, MDU_DIVU:                w_fix_res = w_quo;
        MDU_REM, MDU_REMU:                w_fix_res = w_rem;
        default:                          w_fix_res = '0;
      endcase
    end
  end

  // FSM, counter and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MDU_IDLE;
      r_cnt      <= '0;
      r_func3    <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_acc      <= '0;
      r_mag      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        // Kill wins over everything, including a same-cycle start.
        r_state <= MDU_IDLE;
      end else begin
        case (r_state)
          MDU_IDLE: begin
            if (start) begin
              r_func3    <= func3;
              r_neg_main <= w_sa ^ w_sb;
              r_neg_rem  <= w_sa;
              r_spec     <= w_special;
              r_spec_res <= w_spec_res;
              r_cnt      <= CNT_W'(MDU_ITER - 1);
              if (w_is_div) begin
                r_acc <= {{XLEN{1'b0}}, w_abs_a};
                r_mag <= w_abs_b;
              end else begin
                r_acc <= {{XLEN{1'b0}}, w_abs_b};
                r_mag <= w_abs_a;
              end
              r_state <= (EARLY_OUT && w_special) ? MDU_FIX : MDU_CALC;
            end
          end
          MDU_CALC: begin
            r_acc <= r_func3[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state <= MDU_FIX;
            end
          end
          MDU_FIX: begin
            r_result <= w_fix_res;
            r_done   <= 1'b1;
            r_state  <= MDU_IDLE;
          end
          default: r_state <= MDU_IDLE;
        endcase
      end
    end
  end

  assign busy   = (r_state != MDU_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_rv32m_mdu.sv
// ---------------------------------------------------------------------------
// tb_rv32m_mdu
// Directed self-checking bench for rv32m_mdu with a result scoreboard.
// ---------------------------------------------------------------------------
module tb_rv32m_mdu;
  import rv32m_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

`ifdef MDU_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  always #5 clk = ~clk;

  rv32m_mdu #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model built on SystemVerilog 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    logic signed [63:0] xp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic signed [31:0] sq;
    logic               ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    up  = {32'b0, a} * {32'b0, b};
    xa  = {{32{a[31]}}, a};
    xb  = {{32{b[31]}}, b};
    case (f)
      MDU_MUL:   return up[31:0];
      MDU_MULH:  begin xp = xa * xb; return xp[63:32]; end
      MDU_MULHSU: begin xb = {32'b0, b}; xp = xa * xb; return xp[63:32]; end
      MDU_MULHU: return up[63:32];
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = sa / sbv;
        return sq;
      end
      MDU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sq = sa % sbv;
        return sq;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 0) return SPEC_LAT;
    if ((f == MDU_DIV || f == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return SPEC_LAT;
    return 33;
  endfunction

  // Called just after a clock edge while the unit is idle; returns just
  // after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    chk("idle_before_start", 32'(busy), 32'd0);
    func3 = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (push) sb_q.push_back(exp);
    step();
    start = 1'b0;
  endtask

  // Counts edges from the current point to done, then checks busy and the
  // scoreboard. Returns in the done cycle so the caller may issue again.
  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    int bcnt = 0;
    logic [31:0] exp;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bcnt++;
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(lat));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk({tag, "_result"}, result, exp);
    end
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int d = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done === 1'b1) d++;
    end
    chk(tag, 32'(d), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b1;
    step();

    // Basic multiply with latency and busy profile
    issue(MDU_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
    chk("mul_busy_after_accept", 32'(busy), 32'd1);
    wait_done("mul_7x6", 33);
    step();
    chk("done_single_pulse", 32'(done), 32'd0);

    // High-half multiplies, issued back-to-back in each done cycle
    issue(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    wait_done("mulh_m1", 33);
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    wait_done("mulhu_m1", 33);
    issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("mulhsu_m1", 33);
    issue(MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b1);
    wait_done("mul_m1", 33);

    // Signed / unsigned divide
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    wait_done("div_m7_2", 33);
    issue(MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    wait_done("rem_m7_2", 33);
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b1);
    wait_done("divu_m7_2", 33);
    issue(MDU_REMU, 32'hFFFF_FFF9, 32'd2, 32'h1, 1'b1);
    wait_done("remu_m7_2", 33);

    // Special cases
    issue(MDU_DIV, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_by0", SPEC_LAT);
    issue(MDU_REM, 32'd123, 32'd0, 32'd123, 1'b1);
    wait_done("rem_by0", SPEC_LAT);
    issue(MDU_DIVU, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_by0", SPEC_LAT);
    issue(MDU_REMU, 32'hFFFF_FF85, 32'd0, 32'hFFFF_FF85, 1'b1);
    wait_done("remu_by0", SPEC_LAT);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    wait_done("div_ovf", SPEC_LAT);
    issue(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    wait_done("rem_ovf", SPEC_LAT);
    issue(MDU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    wait_done("mulh_min", 33);

    // Mixed operations against the reference model
    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = (i == 9) ? 32'h0 : $urandom();
      issue(rf, ra, rb, model(rf, ra, rb), 1'b1);
      wait_done("model_op", exp_lat(rf, ra, rb));
    end
    step();

    // start re-pulsed mid-CALC is ignored
    issue(MDU_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
    repeat (5) step();
    func3 = MDU_DIV;
    op_a  = 32'd1000;
    op_b  = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("repulse", 27);
    count_dones("repulse_no_extra_done", 40);

    // flush at iteration 10
    issue(MDU_MUL, 32'd100, 32'd3, 32'd0, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_result_held", result, 32'd42);
    count_dones("flush_no_done", 40);

    // flush and start together in IDLE: not accepted
    func3 = MDU_MUL;
    op_a  = 32'd2;
    op_b  = 32'd2;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    count_dones("flush_start_no_done", 40);
    chk("flush_start_result_held", result, 32'd42);

    // Asynchronous reset at iteration 20
    issue(MDU_MUL, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (19) step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", result, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    issue(MDU_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
    wait_done("mul_3x5_after_rst", 33);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
